// File: rtl/key_repeat_ctl_pkg.sv
// ============================================================================
// key_repeat_ctl_pkg : shared timer package (controller and key-repeat states)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package key_repeat_ctl_pkg;

  // Timer controller states; enable of the key-repeat block follows TC_SET_*.
  typedef enum logic [1:0] {
    TC_RUN     = 2'd0,
    TC_SET_MIN = 2'd1,
    TC_SET_SEC = 2'd2
  } tc_state_t;

  typedef enum logic [2:0] {
    KR_IDLE    = 3'd0,
    KR_HOLD    = 3'd1,
    KR_REPEAT  = 3'd2,
    KR_FAST    = 3'd3,
    KR_LOCKOUT = 3'd4
  } kr_state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } kr_dir_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_repeat_ctl.sv
// ============================================================================
// key_repeat_ctl : up/down button auto-repeat with slow and fast repeat rates
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module key_repeat_ctl
  import key_repeat_ctl_pkg::*;
#(
  parameter int HOLD_TICKS   = 500,
  parameter int REPEAT_TICKS = 100,
  parameter int FAST_TICKS   = 25,
  parameter int FAST_AFTER   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic enable,
  input  logic up_lvl,
  input  logic down_lvl,
  output logic inc,
  output logic dec,
  output logic fast
);

  localparam int CNT_W = $clog2(max3(HOLD_TICKS, REPEAT_TICKS, FAST_TICKS) + 1);
  localparam int REP_W = $clog2(FAST_AFTER + 1);

  // Terminal values: the tick that would bring the count up to the interval.
  localparam logic [CNT_W-1:0] c_HOLD_LAST   = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] c_REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
  localparam logic [CNT_W-1:0] c_FAST_LAST   = CNT_W'(FAST_TICKS - 1);
  localparam logic [REP_W-1:0] c_REP_LAST    = REP_W'(FAST_AFTER - 1);
  localparam logic [REP_W-1:0] c_REP_MAX     = REP_W'(FAST_AFTER);

  kr_state_t        r_state;
  kr_dir_t          r_dir;
  logic [CNT_W-1:0] r_cnt;
  logic [REP_W-1:0] r_rep;
  logic             r_inc;
  logic             r_dec;
  logic             r_fast;

  logic [CNT_W-1:0] w_last;
  logic             w_key_held;
  logic             w_opp_held;

  always_comb begin
    w_last = c_HOLD_LAST;
    case (r_state)
      KR_REPEAT: w_last = c_REPEAT_LAST;
      KR_FAST:   w_last = c_FAST_LAST;
      default:   w_last = c_HOLD_LAST;
    endcase
  end

  assign w_key_held = (r_dir == DIR_UP) ? up_lvl   : down_lvl;
  assign w_opp_held = (r_dir == DIR_UP) ? down_lvl : up_lvl;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= KR_IDLE;
      r_dir   <= DIR_UP;
      r_cnt   <= '0;
      r_rep   <= '0;
      r_inc   <= 1'b0;
      r_dec   <= 1'b0;
      r_fast  <= 1'b0;
    end else begin
      r_inc  <= 1'b0;
      r_dec  <= 1'b0;
      r_fast <= (r_state == KR_FAST);
      case (r_state)
        KR_IDLE: begin
          if (enable && (up_lvl ^ down_lvl)) begin
            r_dir   <= up_lvl ? DIR_UP : DIR_DOWN;
            r_cnt   <= '0;
            r_inc   <= up_lvl;
            r_dec   <= down_lvl;
            r_state <= KR_HOLD;
          end else if (enable && up_lvl && down_lvl) begin
            r_state <= KR_LOCKOUT;
          end
        end
        KR_HOLD, KR_REPEAT, KR_FAST: begin
          if (!enable || !w_key_held) begin
            r_cnt   <= '0;
            r_state <= KR_IDLE;
          end else if (w_opp_held) begin
            r_cnt   <= '0;
            r_state <= KR_LOCKOUT;
          end else if (tick) begin
            if (r_cnt == w_last) begin
              r_cnt <= '0;
              r_inc <= (r_dir == DIR_UP);
              r_dec <= (r_dir == DIR_DOWN);
              if (r_state == KR_HOLD) begin
                r_rep   <= '0;
                r_state <= KR_REPEAT;
              end else if (r_state == KR_REPEAT) begin
                if (r_rep != c_REP_MAX) begin
                  r_rep <= r_rep + 1'b1;
                end
                if (r_rep == c_REP_LAST) begin
                  r_state <= KR_FAST;
                end
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        KR_LOCKOUT: begin
          if (!up_lvl && !down_lvl) begin
            r_state <= KR_IDLE;
          end
        end
        default: r_state <= KR_IDLE;
      endcase
    end
  end

  assign inc  = r_inc;
  assign dec  = r_dec;
  assign fast = r_fast;

endmodule

`default_nettype wire

// File: tb/tb_key_repeat_ctl.sv
// ============================================================================
// tb_key_repeat_ctl : directed self-checking bench for key_repeat_ctl
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_repeat_ctl;

  logic clk = 1'b0;
  logic reset, tick, enable, up_lvl, down_lvl;
  logic inc, dec, fast;

  int n_checks = 0;
  int n_errors = 0;

  key_repeat_ctl #(
    .HOLD_TICKS  (4),
    .REPEAT_TICKS(2),
    .FAST_TICKS  (1),
    .FAST_AFTER  (3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick),
    .enable  (enable),
    .up_lvl  (up_lvl),
    .down_lvl(down_lvl),
    .inc     (inc),
    .dec     (dec),
    .fast    (fast)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bit c of each mask is the value for cycle c; cycle 0 is the first cycle after reset.
  task automatic run_scn(input string name,
                         input logic [31:0] up_m, input logic [31:0] dn_m,
                         input logic [31:0] en_m, input logic [31:0] tk_m,
                         input logic [31:0] rst_m,
                         input logic [31:0] exp_inc, input logic [31:0] exp_dec,
                         input logic [31:0] exp_fast, input int ncyc);
    reset = 1'b1; up_lvl = 1'b0; down_lvl = 1'b0; enable = 1'b0; tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < ncyc; c++) begin
      reset    = rst_m[c];
      up_lvl   = up_m[c];
      down_lvl = dn_m[c];
      enable   = en_m[c];
      tick     = tk_m[c];
      chk($sformatf("%s inc c%0d", name, c),  {31'd0, inc},  {31'd0, exp_inc[c]});
      chk($sformatf("%s dec c%0d", name, c),  {31'd0, dec},  {31'd0, exp_dec[c]});
      chk($sformatf("%s fast c%0d", name, c), {31'd0, fast}, {31'd0, exp_fast[c]});
      chk($sformatf("%s excl c%0d", name, c), {31'd0, inc & dec}, 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; enable = 1'b0; up_lvl = 1'b0; down_lvl = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset inc", {31'd0, inc}, 32'd0);
    chk("reset dec", {31'd0, dec}, 32'd0);
    chk("reset fast", {31'd0, fast}, 32'd0);

    // up held: hold, slow repeat, then fast repeat
    run_scn("up_hold", 32'h000F_FFFF, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,
            32'h000F_FAA2, 32'h0, 32'h000F_F000, 20);
    // short down press: single dec
    run_scn("down_short", 32'h0, 32'h7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,
            32'h0, 32'h2, 32'h0, 12);
    // both pressed: lockout until both low, then fresh up press
    run_scn("both_lock", 32'h000F_F3FF, 32'h7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,
            32'h000A_2000, 32'h0, 32'h0, 20);
    // opposite key during repeat: suppressed pulse, lockout
    run_scn("opp_key", 32'h000F_9FFF, 32'h700, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,
            32'h0001_00A2, 32'h0, 32'h0, 20);
    // enable drop on an expiry cycle, then re-enable with key held
    run_scn("en_drop", 32'h000F_FFFF, 32'h0, 32'h000F_FC3F, 32'hFFFF_FFFF, 32'h0,
            32'h000A_8822, 32'h0, 32'h0, 20);
    // reset during repeat, then fresh press
    run_scn("mid_reset", 32'h000F_E7FF, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h400,
            32'h0004_42A2, 32'h0, 32'h0, 20);
    // tick every other cycle stretches intervals
    run_scn("slow_tick", 32'h0, 32'h000F_FFFF, 32'hFFFF_FFFF, 32'h0005_5555, 32'h0,
            32'h0, 32'h0002_2202, 32'h0, 20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
